// File: rtl/adc_stream_recorder.sv
// adc_stream_recorder: AXI-Stream ADC sample recorder with frame detection and a prefetching FIFO read port.
// Ports:
//   aclk, aresetn             clock, asynchronous active-low reset
//   s_axis_tvalid/tready/tdata upstream beats {timestamp, sample}; tready low while full
//   clear                      synchronous flush of FIFO, counters and frame tracking
//   rd_valid/rd_ready          consumer handshake; rd_sample/rd_ts/rd_frame_start describe the head entry
//   level                      entries held (RAM + prefetch + output register)
//   frames_count, drop_count   saturating frame-start and dropped-beat counters
//   overflow                   sticky drop flag
//   last_ts                    timestamp of the last accepted beat
module adc_stream_recorder #(
    parameter int SAMPLE_WIDTH = 15,
    parameter int TS_WIDTH     = 49,
    parameter int ADDR_WIDTH   = 10
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    input  logic [63:0]             s_axis_tdata,
    input  logic                    clear,
    output logic                    rd_valid,
    input  logic                    rd_ready,
    output logic signed [SAMPLE_WIDTH-1:0] rd_sample,
    output logic [TS_WIDTH-1:0]     rd_ts,
    output logic                    rd_frame_start,
    output logic [ADDR_WIDTH:0]     level,
    output logic [15:0]             frames_count,
    output logic [31:0]             drop_count,
    output logic                    overflow,
    output logic [TS_WIDTH-1:0]     last_ts
);
    localparam int EW = 1 + TS_WIDTH + SAMPLE_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [EW-1:0]         mem [2**ADDR_WIDTH];
    logic [EW-1:0]         ram_dout_q;
    logic [EW-1:0]         out_q, out_d;
    logic                  out_valid_q, out_valid_d;
    logic                  pf_q, pf_d;
    logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   level_q, level_d;
    logic                  tready_q, tready_d;
    logic [15:0]           frames_q, frames_d;
    logic [31:0]           drops_q, drops_d;
    logic                  overflow_q, overflow_d;
    logic [TS_WIDTH-1:0]   last_ts_q, last_ts_d;
    logic                  have_prev_q, have_prev_d;
    logic [TS_WIDTH-1:0]   ts_in;
    logic                  accept, drop, frame_start, pop, pf_move, issue;

    assign ts_in       = s_axis_tdata[SAMPLE_WIDTH +: TS_WIDTH];
    assign accept      = s_axis_tvalid && tready_q && !clear;
    assign drop        = s_axis_tvalid && !tready_q && !clear;
    assign frame_start = !have_prev_q || (ts_in != TS_WIDTH'(last_ts_q + 1'b1));
    assign pop         = out_valid_q && rd_ready;
    // Prefetch slot advances into the output register whenever that register frees up;
    // a new RAM read may refill the slot in the same cycle, sustaining one entry per cycle.
    assign pf_move     = pf_q && (!out_valid_q || pop);
    assign issue       = (wr_ptr_q != rd_ptr_q) && (!pf_q || pf_move);

    always_comb begin
        wr_ptr_d    = clear ? '0 : wr_ptr_q + (ADDR_WIDTH+1)'(accept);
        rd_ptr_d    = clear ? '0 : rd_ptr_q + (ADDR_WIDTH+1)'(issue);
        level_d     = clear ? '0 : level_q + (ADDR_WIDTH+1)'(accept) - (ADDR_WIDTH+1)'(pop);
        tready_d    = level_d != DEPTH;
        pf_d        = clear ? 1'b0 : issue ? 1'b1 : pf_move ? 1'b0 : pf_q;
        out_valid_d = clear ? 1'b0 : pf_move ? 1'b1 : pop ? 1'b0 : out_valid_q;
        out_d       = pf_move ? ram_dout_q : out_q;
        frames_d    = clear ? '0 : (accept && frame_start && frames_q != 16'hFFFF) ? frames_q + 16'd1 : frames_q;
        drops_d     = clear ? '0 : (drop && drops_q != 32'hFFFF_FFFF) ? drops_q + 32'd1 : drops_q;
        overflow_d  = clear ? 1'b0 : overflow_q || drop;
        last_ts_d   = clear ? '0 : accept ? ts_in : last_ts_q;
        have_prev_d = clear ? 1'b0 : accept ? 1'b1 : have_prev_q;
    end

    // Simple dual-port RAM with registered read; contents need no reset.
    always_ff @(posedge aclk) begin
        if (accept)
            mem[wr_ptr_q[ADDR_WIDTH-1:0]] <= {frame_start, ts_in, s_axis_tdata[SAMPLE_WIDTH-1:0]};
        if (issue)
            ram_dout_q <= mem[rd_ptr_q[ADDR_WIDTH-1:0]];
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            tready_q    <= 1'b1;
            pf_q        <= 1'b0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            frames_q    <= '0;
            drops_q     <= '0;
            overflow_q  <= 1'b0;
            last_ts_q   <= '0;
            have_prev_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            tready_q    <= tready_d;
            pf_q        <= pf_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            frames_q    <= frames_d;
            drops_q     <= drops_d;
            overflow_q  <= overflow_d;
            last_ts_q   <= last_ts_d;
            have_prev_q <= have_prev_d;
        end
    end

    assign s_axis_tready  = tready_q;
    assign rd_valid       = out_valid_q;
    assign rd_frame_start = out_q[EW-1];
    assign rd_ts          = out_q[SAMPLE_WIDTH +: TS_WIDTH];
    assign rd_sample      = out_q[SAMPLE_WIDTH-1:0];
    assign level          = level_q;
    assign frames_count   = frames_q;
    assign drop_count     = drops_q;
    assign overflow       = overflow_q;
    assign last_ts        = last_ts_q;
endmodule
